// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio decimator.
package audio_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Sum of 2^max_shift samples needs max_shift extra bits of headroom.
  function automatic int acc_width(input int data_width, input int max_shift);
    return data_width + max_shift;
  endfunction

endpackage

// File: rtl/audio_decimator_if.sv
// Input and output frame streams of the audio decimator, each with valid/ready.
interface audio_decimator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2
);
  logic [DATA_WIDTH*NUM_CH-1:0] audio_in;
  logic                         valid_in;
  logic                         ready_in;
  logic [DATA_WIDTH*NUM_CH-1:0] audio_out;
  logic                         valid_out;
  logic                         ready_out;

  modport master (
    output audio_in, valid_in, ready_out,
    input  ready_in, audio_out, valid_out
  );

  modport slave (
    input  audio_in, valid_in, ready_out,
    output ready_in, audio_out, valid_out
  );
endinterface

// File: rtl/audio_decim_ch.sv
// One channel of the decimator datapath: keeps the last sample of a group, or
// with AUDIO_DECIM_AVG_EN defined, sums the group and outputs sum >>> shift.
module audio_decim_ch
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = 16
`ifdef AUDIO_DECIM_AVG_EN
  , parameter int MAX_SHIFT = 4
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic                         accept,
  input  logic                         last,
  output logic        [DATA_WIDTH-1:0] out_sample
`ifdef AUDIO_DECIM_AVG_EN
  , input logic                            first,
  input  logic [$clog2(MAX_SHIFT+1)-1:0]   shift
`endif
);
  logic [DATA_WIDTH-1:0] out_reg;

`ifdef AUDIO_DECIM_AVG_EN
  localparam int ACC_W = acc_width(DATA_WIDTH, MAX_SHIFT);

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] sum;
  logic [DATA_WIDTH-1:0]   avg;

  // Frame 0 loads rather than adds, so no separate clear cycle is needed.
  always_comb begin
    sum = first ? ACC_W'(sample) : acc_reg + ACC_W'(sample);
    avg = DATA_WIDTH'(sum >>> shift);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg <= '0;
      out_reg <= '0;
    end else if (accept) begin
      acc_reg <= sum;
      if (last) out_reg <= avg;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset_n) out_reg <= '0;
    else if (accept && last) out_reg <= sample;
  end
`endif

  assign out_sample = out_reg;
endmodule

// File: rtl/audio_decimator.sv
// Multi-channel audio decimator: one output frame per 2^decim_shift input frames.
// Define AUDIO_DECIM_AVG_EN to average each group instead of keeping its last frame.
module audio_decimator
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int MAX_SHIFT  = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [$clog2(MAX_SHIFT+1)-1:0] decim_shift,
  audio_decimator_if.slave               bus
);
  localparam int SHIFT_W = $clog2(MAX_SHIFT + 1);
  localparam int CNT_W   = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;

  state_t                       state_reg, state_next;
  logic [CNT_W-1:0]             count_reg;
  logic [SHIFT_W-1:0]           shift_reg, shift_sat, group_shift;
  logic                         ready, valid, accept, out_fire, first, last;
  logic [DATA_WIDTH*NUM_CH-1:0] frame_out;

  // The ratio is latched on frame 0 so a mid-group change waits for the next group.
  always_comb begin
    shift_sat   = (decim_shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : decim_shift;
    first       = (count_reg == '0);
    group_shift = first ? shift_sat : shift_reg;
    last        = (count_reg == CNT_W'((32'd1 << group_shift) - 32'd1));
  end

  always_comb begin
    state_next = state_reg;
    valid      = (state_reg == HOLD);
    ready      = (state_reg == ACCUM) || bus.ready_out;
    accept     = bus.valid_in && ready;
    out_fire   = valid && bus.ready_out;
    case (state_reg)
      ACCUM:   if (accept && last) state_next = HOLD;
      HOLD:    if (out_fire && !(accept && last)) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ACCUM;
      count_reg <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        count_reg <= last ? '0 : count_reg + 1'b1;
        if (first) shift_reg <= shift_sat;
      end
    end
  end

  assign bus.ready_in  = ready;
  assign bus.valid_out = valid;
  assign bus.audio_out = frame_out;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      audio_decim_ch #(
        .DATA_WIDTH (DATA_WIDTH)
`ifdef AUDIO_DECIM_AVG_EN
        , .MAX_SHIFT (MAX_SHIFT)
`endif
      ) u_ch (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample     (bus.audio_in[gi*DATA_WIDTH +: DATA_WIDTH]),
        .accept     (accept),
        .last       (last),
        .out_sample (frame_out[gi*DATA_WIDTH +: DATA_WIDTH])
`ifdef AUDIO_DECIM_AVG_EN
        , .first    (first),
        .shift      (group_shift)
`endif
      );
    end
  endgenerate
endmodule

// File: doc/audio_decimator.md
AUDIO_DECIMATOR -- requirements
Module: audio_decimator

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed sample width per channel.
REQ-002 Parameter NUM_CH, default 2: channels packed per frame; channel 0 occupies the LSBs.
REQ-003 Parameter MAX_SHIFT, default 4: largest supported log2 decimation ratio.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 Port decim_shift, input, $clog2(MAX_SHIFT+1): ratio R = 2^decim_shift.
REQ-007 Port audio_in, input, DATA_WIDTH*NUM_CH: input frame.
REQ-008 Port valid_in, input, 1: audio_in is valid.
REQ-009 Port ready_in, output, 1: block accepts a frame; a transfer occurs when valid_in and ready_in are both high.
REQ-010 Port audio_out, output, DATA_WIDTH*NUM_CH: decimated frame.
REQ-011 Port valid_out, output, 1: audio_out is valid; held high until accepted.
REQ-012 Port ready_out, input, 1: downstream accepts; a transfer occurs when valid_out and ready_out are both high.

Function
REQ-013 The block SHALL emit exactly one output frame per R accepted input frames.
REQ-014 The frame counter SHALL count accepted input frames from 0 to R-1 and wrap to 0 on the R-th.
REQ-015 States: ACCUM (collecting frames) and HOLD (valid_out high, awaiting ready_out).
- ACCUM->HOLD on acceptance of the R-th frame.
- HOLD->ACCUM on an output transfer.
REQ-016 ready_in SHALL equal (state==ACCUM) OR ready_out.
- In HOLD with ready_out high, an input frame and an output frame SHALL transfer in the same cycle; that input is counted as frame 0 of the next group.
- In that same-cycle case, if R==1 the block SHALL stay in HOLD and load the new output.
REQ-017 Latency: valid_out and audio_out SHALL update on the clock edge that accepts the R-th frame, so they are visible one cycle after that handshake.
REQ-018 audio_out SHALL remain stable while valid_out is high and ready_out is low.
REQ-019 decim_shift SHALL be sampled only when the counter is 0 and a frame is accepted. Changes mid-group SHALL take effect at the next group.
REQ-020 decim_shift values greater than MAX_SHIFT SHALL be saturated to MAX_SHIFT.
REQ-021 Without averaging (see REQ-026), each output channel SHALL equal the corresponding channel of the R-th frame of the group.

Reset
REQ-022 While reset_n is low at a rising edge, the block SHALL:
- clear the counter, accumulators, audio_out and valid_out to 0;
- set the state to ACCUM, with ready_in high after reset.
REQ-023 Reset mid-group or during HOLD SHALL discard the partial group and any pending output.
REQ-024 The first group after reset SHALL start from the next accepted frame.

Configuration
REQ-025 Macro AUDIO_DECIM_AVG_EN SHALL select averaging.
REQ-026 With AUDIO_DECIM_AVG_EN defined:
- Each channel SHALL keep a signed accumulator of DATA_WIDTH+MAX_SHIFT bits that sums the R frames of a group.
- Each output channel SHALL be that sum arithmetically right-shifted by decim_shift, then truncated to DATA_WIDTH.
- The accumulator SHALL load the incoming sample, not add to it, on frame 0.
REQ-027 Without AUDIO_DECIM_AVG_EN, no accumulators SHALL exist and the block SHALL behave as REQ-021.

Structure
REQ-028 Package audio_pkg SHALL hold the state enum and a function giving accumulator width from DATA_WIDTH and MAX_SHIFT.
REQ-029 Sub-module audio_decim_ch SHALL provide the per-channel accumulate/select datapath, instantiated NUM_CH times by generate.
REQ-030 The counter, FSM and handshake logic SHALL live in the top level.

Verification
REQ-031 decim_shift=2, averaging on, ch0 inputs 4,8,12,16 -> one output with ch0=10, one cycle after the 4th handshake.
REQ-032 decim_shift=2, averaging off, ch1 inputs 1,2,3,-7 -> ch1=-7; exactly 1 output per 4 inputs over 400 frames.
REQ-033 decim_shift=0, valid_in constant high, ready_out toggling 1,0 -> no frame lost or duplicated; audio_out stable while stalled; ready_in low in HOLD when ready_out is low.
REQ-034 decim_shift=3, averaging on, all 8 ch0 inputs -32768 -> output -32768 with no overflow; all 8 inputs +32767 -> output +32767.
REQ-035 reset_n low after 2 of 4 frames -> valid_out=0 and audio_out=0 the next cycle; the next 4 frames produce an output averaged only over themselves.
REQ-036 decim_shift changed from 1 to 3 mid-group -> the current group completes at 2 frames, and the following groups use 8 frames.
